// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp,
// datapath mux selects, FSM state encoding and the control-word payload.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W    = 6;
    localparam int unsigned STATE_ENC_W = 4;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'd12;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;

    // ALUOp values consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_RFORMAT = 2'b10;
    localparam logic [1:0] ALUOP_AND     = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef enum logic [STATE_ENC_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EX    = 4'd6,
        S_R_WB    = 4'd7,
        S_BEQ     = 4'd8,
        S_J       = 4'd9,
        S_JAL     = 4'd10,
        S_JR      = 4'd11,
        S_ADDI_EX = 4'd12,
        S_ANDI_EX = 4'd13,
        S_IMM_WB  = 4'd14
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_LW, OP_SW: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable and select.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                jr,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: only FETCH and the memory-access states wait on mem_ready
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_RTYPE:     state_d = S_R_EX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_J;
                    OP_JAL:       state_d = S_JAL;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ANDI:      state_d = S_ANDI_EX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:  state_d = S_FETCH;
            S_MEM_WR:  state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:    state_d = jr ? S_JR : S_R_WB;
            S_R_WB:    state_d = S_FETCH;
            S_BEQ:     state_d = S_FETCH;
            S_J:       state_d = S_FETCH;
            S_JAL:     state_d = S_FETCH;
            S_JR:      state_d = S_FETCH;
            S_ADDI_EX: state_d = S_IMM_WB;
            S_ANDI_EX: state_d = S_IMM_WB;
            S_IMM_WB:  state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore decode; reset forces every control low even though state is FETCH
    always_comb begin
        ctl = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_op    = ALUOP_ADD;
                ctl.illegal   = ~is_legal_op(opcode);
            end
            S_MEM_ADR, S_ADDI_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = REGDST_RT;
                ctl.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            S_R_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALUOP_RFORMAT;
            end
            S_R_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = REGDST_RD;
                ctl.mem_to_reg = M2R_ALUOUT;
            end
            S_JR: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_A;
            end
            S_BEQ: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_B;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
            end
            S_J: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
            end
            // PC already holds PC+4, so it is the link value
            S_JAL: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PCSRC_JUMP;
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = REGDST_RA;
                ctl.mem_to_reg = M2R_PC;
            end
            S_ANDI_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_AND;
            end
            S_IMM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = REGDST_RT;
                ctl.mem_to_reg = M2R_ALUOUT;
            end
            default: ctl = '0;
        endcase
        if (!reset_n) begin
            ctl = '0;
        end
    end

    assign pc_write      = ctl.pc_write;
    assign pc_write_cond = ctl.pc_write_cond;
    assign i_or_d        = ctl.i_or_d;
    assign mem_read      = ctl.mem_read;
    assign mem_write     = ctl.mem_write;
    assign ir_write      = ctl.ir_write;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign reg_dst       = ctl.reg_dst;
    assign reg_write     = ctl.reg_write;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign alu_op        = ctl.alu_op;
    assign pc_source     = ctl.pc_source;
    assign illegal       = ctl.illegal;
    assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and full control-word
// checks against hand-written expectations for each instruction class.
module tb_multicycle_control;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       jr;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] mem_to_reg, reg_dst;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal;
    logic [3:0] state;

    int vectors;
    int miscompares;

    // Control word order:
    // pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    // mem_to_reg[2], reg_dst[2], reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2], illegal
    logic [18:0] ctl;
    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, illegal};

    localparam logic [18:0] E_ZERO    = 19'd0;
    localparam logic [18:0] E_FETCH_W = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [18:0] E_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [18:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [18:0] E_DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
    localparam logic [18:0] E_MEM_ADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [18:0] E_MEM_RD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [18:0] E_MEM_WB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [18:0] E_MEM_WR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [18:0] E_R_EX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [18:0] E_R_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [18:0] E_JR      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b11,1'b0};
    localparam logic [18:0] E_BEQ     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [18:0] E_J       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [18:0] E_JAL     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b10,1'b1,1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [18:0] E_ADDI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [18:0] E_ANDI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b11,2'b00,1'b0};
    localparam logic [18:0] E_IMM_WB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};

    multicycle_control #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .jr            (jr),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal       (illegal),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tasks start and end on a falling edge; inputs change there, checks land 1 time unit later
    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0; jr = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        vectors++;
        if (state !== 4'd0) begin
            miscompares++; $display("FAIL reset_state: got %0d want 0", state);
        end
        vectors++;
        if (ctl !== E_ZERO) begin
            miscompares++; $display("FAIL reset_outputs: got %h want %h", ctl, E_ZERO);
        end
        reset_n = 1'b1; mem_ready = 1'b0;
        #1;
        vectors++;
        if (ctl !== E_FETCH_W || state !== 4'd0) begin
            miscompares++; $display("FAIL reset_release: got st=%0d ctl=%h want st=0 ctl=%h", state, ctl, E_FETCH_W);
        end
        @(negedge clk);
        vectors++;
        if (state !== 4'd0) begin
            miscompares++; $display("FAIL reset_fetch_hold: got %0d want 0", state);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  st [4];
        logic [18:0] cv [4];
        st = '{4'd0, 4'd1, 4'd6, 4'd7};
        cv = '{E_FETCH_R, E_DECODE, E_R_EX, E_R_WB};
        opcode = 6'd0; jr = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (state !== st[i]) begin
                miscompares++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            vectors++;
            if (ctl !== cv[i]) begin
                miscompares++; $display("FAIL rtype_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
            end
            @(negedge clk);
        end
        vectors++;
        if (state !== 4'd0) begin
            miscompares++; $display("FAIL rtype_len: got %0d want 0", state);
        end
    endtask

    task automatic test_jr();
        logic [3:0]  st [4];
        logic [18:0] cv [4];
        st = '{4'd0, 4'd1, 4'd6, 4'd11};
        cv = '{E_FETCH_R, E_DECODE, E_R_EX, E_JR};
        opcode = 6'd0; jr = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (state !== st[i]) begin
                miscompares++; $display("FAIL jr_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            vectors++;
            if (ctl !== cv[i]) begin
                miscompares++; $display("FAIL jr_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
            end
            @(negedge clk);
        end
        jr = 1'b0;
        vectors++;
        if (state !== 4'd0) begin
            miscompares++; $display("FAIL jr_len: got %0d want 0", state);
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  st [10];
        logic [18:0] cv [10];
        logic        rdy [10];
        int          ir_pulses;
        st  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        cv  = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_MEM_ADR,
                E_MEM_RD, E_MEM_RD, E_MEM_RD, E_MEM_RD, E_MEM_WB};
        rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ir_pulses = 0;
        opcode = 6'd35; jr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = rdy[i];
            #1;
            if (ir_write === 1'b1) ir_pulses++;
            vectors++;
            if (state !== st[i]) begin
                miscompares++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            vectors++;
            if (ctl !== cv[i]) begin
                miscompares++; $display("FAIL lw_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
            end
            @(negedge clk);
        end
        vectors++;
        if (ir_pulses != 1) begin
            miscompares++; $display("FAIL lw_ir_pulses: got %0d want 1", ir_pulses);
        end
        vectors++;
        if (state !== 4'd0) begin
            miscompares++; $display("FAIL lw_len: got %0d want 0", state);
        end
    endtask

    task automatic test_andi_jal();
        logic [3:0]  st [7];
        logic [18:0] cv [7];
        logic [5:0]  op [7];
        st = '{4'd0, 4'd1, 4'd13, 4'd14, 4'd0, 4'd1, 4'd10};
        cv = '{E_FETCH_R, E_DECODE, E_ANDI, E_IMM_WB, E_FETCH_R, E_DECODE, E_JAL};
        op = '{6'd12, 6'd12, 6'd12, 6'd12, 6'd3, 6'd3, 6'd3};
        jr = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            opcode = op[i];
            #1;
            vectors++;
            if (state !== st[i]) begin
                miscompares++; $display("FAIL andi_jal_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            vectors++;
            if (ctl !== cv[i]) begin
                miscompares++; $display("FAIL andi_jal_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
            end
            @(negedge clk);
        end
        vectors++;
        if (state !== 4'd0) begin
            miscompares++; $display("FAIL andi_jal_len: got %0d want 0", state);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  st [4];
        logic [18:0] cv [4];
        logic        rdy [4];
        int          ill_pulses;
        st  = '{4'd0, 4'd1, 4'd0, 4'd0};
        cv  = '{E_FETCH_R, E_DEC_ILL, E_FETCH_W, E_FETCH_W};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        ill_pulses = 0;
        opcode = 6'd63; jr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            #1;
            if (illegal === 1'b1) ill_pulses++;
            vectors++;
            if (state !== st[i]) begin
                miscompares++; $display("FAIL illegal_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            vectors++;
            if (ctl !== cv[i]) begin
                miscompares++; $display("FAIL illegal_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
            end
            @(negedge clk);
        end
        vectors++;
        if (ill_pulses != 1) begin
            miscompares++; $display("FAIL illegal_pulses: got %0d want 1", ill_pulses);
        end
    endtask

    // beq, j, sw (one memory wait), addi issued back to back
    task automatic test_back_to_back();
        logic [3:0]  st [15];
        logic [18:0] cv [15];
        logic [5:0]  op [15];
        logic        rdy [15];
        st  = '{4'd0, 4'd1, 4'd8,  4'd0, 4'd1, 4'd9,
                4'd0, 4'd1, 4'd2, 4'd5, 4'd5,  4'd0, 4'd1, 4'd12, 4'd14};
        cv  = '{E_FETCH_R, E_DECODE, E_BEQ, E_FETCH_R, E_DECODE, E_J,
                E_FETCH_R, E_DECODE, E_MEM_ADR, E_MEM_WR, E_MEM_WR,
                E_FETCH_R, E_DECODE, E_ADDI, E_IMM_WB};
        op  = '{6'd4, 6'd4, 6'd4, 6'd2, 6'd2, 6'd2,
                6'd43, 6'd43, 6'd43, 6'd43, 6'd43, 6'd8, 6'd8, 6'd8, 6'd8};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        jr = 1'b0;
        for (int i = 0; i < 15; i++) begin
            opcode = op[i]; mem_ready = rdy[i];
            #1;
            vectors++;
            if (state !== st[i]) begin
                miscompares++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            vectors++;
            if (ctl !== cv[i]) begin
                miscompares++; $display("FAIL b2b_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
            end
            @(negedge clk);
        end
        vectors++;
        if (state !== 4'd0) begin
            miscompares++; $display("FAIL b2b_len: got %0d want 0", state);
        end
    endtask

    // Asynchronous reset while lw is stalled in MEM_RD
    task automatic test_reset_mid();
        logic [3:0] st [3];
        st = '{4'd0, 4'd1, 4'd2};
        opcode = 6'd35; jr = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (state !== st[i]) begin
                miscompares++; $display("FAIL rstmid_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd3 || ctl !== E_MEM_RD) begin
            miscompares++; $display("FAIL rstmid_memrd: got st=%0d ctl=%h want st=3 ctl=%h", state, ctl, E_MEM_RD);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0 || ctl !== E_ZERO) begin
            miscompares++; $display("FAIL rstmid_abort: got st=%0d ctl=%h want st=0 ctl=%h", state, ctl, E_ZERO);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (state !== 4'd0 || ctl !== E_ZERO) begin
            miscompares++; $display("FAIL rstmid_hold: got st=%0d ctl=%h want st=0 ctl=%h", state, ctl, E_ZERO);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        vectors++;
        if (state !== 4'd0 || ctl !== E_FETCH_W) begin
            miscompares++; $display("FAIL rstmid_release: got st=%0d ctl=%h want st=0 ctl=%h", state, ctl, E_FETCH_W);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        opcode      = 6'd0;
        jr          = 1'b0;
        mem_ready   = 1'b0;
        test_reset();
        test_rtype();
        test_jr();
        test_lw_wait();
        test_andi_jal();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It is the producer side of the ALUOp interface that the ALU control decoder consumes.
- Sequences each instruction through fetch, decode, execute, memory and writeback. It drives all datapath enables and muxes, and the 2-bit alu_op.
- Consumes the decoder's jr flag to redirect R-type jr instructions.
- Waits on a memory ready handshake for every instruction and data access.

Parameters:
- STATE_W, 4, width of the state register (15 states used).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- jr  in  1  from ALU control; high when alu_op=RFORMAT and funct=8
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC
- reg_dst  out  2  write register: 00 rt, 01 rd, 10 $31
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- alu_op  out  2  00 ADD, 01 SUB, 10 RFORMAT, 11 AND
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr)
- illegal  out  1  one-cycle pulse on unknown opcode
- state  out  STATE_W  current state, for debug

Behaviour:
- Opcodes: R=0, j=2, jal=3, beq=4, addi=8, andi=12, lw=35, sw=43.
- Reset: while reset_n=0, state=FETCH and all outputs are forced to 0. Reset is asynchronous, so it aborts any instruction mid-flight with no writes committed. The first FETCH cycle follows deassertion.
- Outputs are a Moore decode of state. Exceptions are ir_write, pc_write in FETCH, and the MEM_RD/MEM_WR exits, which are gated by mem_ready. Any control not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: lw/sw -> MEM_ADR; R -> R_EX; beq -> BEQ; j -> J; jal -> JAL; addi -> ADDI_EX; andi -> ANDI_EX.
  - Any other opcode -> FETCH, with illegal=1 for this cycle.
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
- R_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to JR if jr=1, else R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00. Then FETCH.
- JR: pc_write=1, pc_source=11, with no register write. Then FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
- J: pc_write=1, pc_source=10. Then FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. The link value is PC+4, already in PC. Then FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Then IMM_WB.
- ANDI_EX: alu_src_a=1, alu_src_b=10, alu_op=11. The decoder's sign=0 makes the immediate extender zero-extend. Then IMM_WB.
- IMM_WB: reg_write=1, reg_dst=00, mem_to_reg=00. Then FETCH.
- Cycle counts with zero wait states:
  - beq, j, jal: 3
  - R, jr, sw, addi, andi: 4
  - lw: 5
  - Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read and mem_write are never high together. reg_write and pc_write coincide only in JAL.
- A mem_ready pulse outside FETCH, MEM_RD or MEM_WR is ignored.
- Unreachable state encodings (15) decode to all-zero outputs and go to FETCH.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - ALUOp constants (shared with the ALU control decoder)
  - alu_src_b, pc_source, reg_dst and mem_to_reg encodings
  - state encodings (FETCH=0 … IMM_WB=14)
- No sub-module. A single next-state block plus an output decode block is natural.

Test Plan:
- Reset mid-MEM_RD (lw in flight, mem_ready=0): assert reset_n=0 -> state=0 and all outputs 0 at once. After release: FETCH with mem_read=1.
- R-type add (opcode 0, jr=0), mem_ready=1 throughout -> states 0,1,6,7. alu_op=10 in R_EX; reg_write=1 and reg_dst=01 in R_WB; 4 cycles.
- jr (opcode 0, jr=1 in R_EX) -> states 0,1,6,11. pc_write=1 and pc_source=11 in JR; reg_write stays 0 throughout.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD -> ir_write pulses only on the ready cycle; reg_write=1 and mem_to_reg=01 in MEM_WB; total 10 cycles.
- andi (12), then jal (3) -> alu_op=11 and alu_src_b=10 in ANDI_EX. JAL drives pc_write=1, reg_dst=10, mem_to_reg=10 in a single cycle.
- Opcode 63 -> illegal=1 for exactly one cycle in DECODE, then FETCH. No reg_write, mem_write or pc_write occurs after the fetch.
